lab3_cache_cache_mem_receiver: RTL and testbench

LAB3_CACHE_CACHE_MEM_RECEIVER -- requirements
Module: lab3_cache_CacheMemReceiver

---
 rtl/lab3_cache_cache_mem_receiver_pkg.sv | 18 +
 rtl/lab3_cache_cache_mem_receiver_control.sv | 37 +++
 rtl/lab3_cache_cache_mem_receiver.sv | 68 ++++++
 tb/tb_lab3_cache_cache_mem_receiver.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lab3_cache_cache_mem_receiver_pkg.sv
// Shared geometry and state encoding for the cache memory-response receiver.
package lab3_cache_cache_mem_receiver_pkg;

  localparam int unsigned LINE_WORDS  = 16;
  localparam int unsigned WORD_BITS   = 32;
  localparam int unsigned LINE_BITS   = 512;
  localparam int unsigned OFFSET_BITS = 6;
  localparam int unsigned CNT_BITS    = 5;
  localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;

  localparam logic [0:0] RECV = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  function automatic logic [LINE_WORDS-1:0] slot_onehot(input logic [3:0] slot);
    return LINE_WORDS'(1) << slot;
  endfunction

endpackage

// File: rtl/lab3_cache_cache_mem_receiver_control.sv
// Receiver FSM: collects beats in RECV, presents the line in DONE until taken.
module lab3_cache_CacheMemReceiver_Control
  import lab3_cache_cache_mem_receiver_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic istream_val,
  input  logic ostream_rdy,
  input  logic last_beat,
  output logic istream_rdy,
  output logic ostream_val,
  output logic accept,
  output logic line_release
);

  logic [0:0] state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RECV;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RECV) begin
      if (accept && last_beat) state_d = DONE;
    end else begin
      if (ostream_rdy) state_d = RECV;
    end
  end

  assign istream_rdy  = (state_q == RECV);
  assign ostream_val  = (state_q == DONE);
  assign accept       = istream_val && istream_rdy;
  assign line_release = ostream_val && ostream_rdy;

endmodule

// File: rtl/lab3_cache_cache_mem_receiver.sv
// Assembles 16 memory words into one 64-byte cache line and hands it downstream.
module lab3_cache_cache_mem_receiver
  import lab3_cache_cache_mem_receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_data,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [31:0]          out_addr,
  output logic [LINE_BITS-1:0] out_data
);

  logic [WORD_BITS-1:0]  slot_q [LINE_WORDS];
  logic [TAG_BITS-1:0]   tag_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  accept;
  logic                  line_release;
  logic                  last_beat;
  logic [LINE_WORDS-1:0] slot_we;
  logic                  unused_in_addr_lsb;

  assign unused_in_addr_lsb = ^in_addr[1:0];
  assign last_beat          = (cnt_q == CNT_BITS'(LINE_WORDS - 1));
  assign slot_we            = accept ? slot_onehot(in_addr[5:2]) : '0;

  lab3_cache_CacheMemReceiver_Control u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .istream_val  (istream_val),
    .ostream_rdy  (ostream_rdy),
    .last_beat    (last_beat),
    .istream_rdy  (istream_rdy),
    .ostream_val  (ostream_val),
    .accept       (accept),
    .line_release (line_release)
  );

  // Handshake clears the line so slots never written by the next line read 0.
  always_ff @(posedge clk) begin
    if (reset || line_release) begin
      cnt_q <= '0;
      tag_q <= '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++) slot_q[i] <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CNT_BITS'(1);
      if (cnt_q == '0) tag_q <= in_addr[31:OFFSET_BITS];
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        if (slot_we[i]) slot_q[i] <= in_data;
      end
    end
  end

  always_comb begin
    out_addr = '0;
    out_data = '0;
    if (ostream_val) begin
      out_addr = {tag_q, OFFSET_BITS'(0)};
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        out_data[i*WORD_BITS +: WORD_BITS] = slot_q[i];
      end
    end
  end

endmodule

// File: tb/tb_lab3_cache_cache_mem_receiver.sv
// Directed and random stimulus checked against a line-level behavioural model.
module tb_lab3_cache_cache_mem_receiver;

  logic         clk = 1'b0;
  logic         reset;
  logic         istream_val;
  logic         istream_rdy;
  logic [31:0]  in_addr;
  logic [31:0]  in_data;
  logic         ostream_val;
  logic         ostream_rdy;
  logic [31:0]  out_addr;
  logic [511:0] out_data;

  always #5 clk = ~clk;

  lab3_cache_cache_mem_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .out_addr    (out_addr),
    .out_data    (out_data)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a line buffer that is either filling or full.
  bit          m_full;
  int          m_count;
  logic [25:0] m_tag;
  logic [31:0] m_words [16];

  function automatic logic [511:0] m_line();
    logic [511:0] l = '0;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = m_words[k];
    return l;
  endfunction

  task automatic m_clear();
    m_full = 0; m_count = 0; m_tag = '0;
    for (int k = 0; k < 16; k++) m_words[k] = '0;
  endtask

  task automatic cycle(input bit rst, input bit val, input logic [31:0] addr,
                       input logic [31:0] data, input bit ordy);
    reset = rst; istream_val = val; in_addr = addr; in_data = data; ostream_rdy = ordy;
    @(posedge clk);
    if (rst) m_clear();
    else if (m_full) begin
      if (ordy) m_clear();
    end else if (val) begin
      if (m_count == 0) m_tag = addr[31:6];
      m_words[addr[5:2]] = data;
      m_count++;
      if (m_count == 16) m_full = 1;
    end
    #1;
    check("istream_rdy", istream_rdy, !m_full);
    check("ostream_val", ostream_val, m_full);
    check("out_addr", out_addr, m_full ? {m_tag, 6'b0} : 32'h0);
    check("out_data", out_data, m_full ? m_line() : 512'h0);
  endtask

  task automatic idle(input bit ordy);
    cycle(0, 0, 32'h0, 32'h0, ordy);
  endtask

  logic [511:0] held;

  initial begin
    m_clear();
    cycle(1, 0, 32'h0, 32'h0, 0);
    cycle(1, 1, 32'hFFFF_FFFF, 32'h1234, 1);
    check("rst_istream_rdy", istream_rdy, 1'b1);
    check("rst_ostream_val", ostream_val, 1'b0);

    // In-order fill
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1, 32'h0000_1000 + 32'(4*k), 32'hA000_0000 + 32'(k), 1);
      if (k < 15) check("inorder_not_early", ostream_val, 1'b0);
    end
    check("inorder_val", ostream_val, 1'b1);
    check("inorder_addr", out_addr, 32'h0000_1000);
    for (int k = 0; k < 16; k++)
      check("inorder_slot", out_data[32*k +: 32], 32'hA000_0000 + 32'(k));
    idle(1);
    check("inorder_back_recv", istream_rdy, 1'b1);

    // Out-of-order fill, junk in byte-offset bits
    for (int k = 15; k >= 0; k--)
      cycle(0, 1, 32'h0000_ABC0 + 32'(4*k) + ($urandom % 4), 32'(k), 0);
    check("ooo_addr", out_addr, 32'h0000_ABC0);
    for (int k = 0; k < 16; k++) check("ooo_slot", out_data[32*k +: 32], 32'(k));

    // Backpressure for 5 cycles, then handshake
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      cycle(0, 1, 32'h0000_2000, 32'hDEAD_BEEF, 0);
      check("bp_rdy_low", istream_rdy, 1'b0);
      check("bp_stable", out_data, held);
    end
    cycle(0, 1, 32'h0000_2000, 32'hDEAD_BEEF, 1);
    check("bp_recv", istream_rdy, 1'b1);

    // Bubbles on istream_val
    for (int k = 0; k < 32; k++)
      cycle(0, (k % 2) == 0, 32'h0000_3000 + 32'(4*(k/2)), 32'h0BB0_0000 + 32'(k/2), 0);
    check("bubble_done", ostream_val, 1'b1);
    idle(1);

    // Reset mid-line, then a clean line of 5s
    for (int k = 0; k < 7; k++) cycle(0, 1, 32'h0000_4000 + 32'(4*k), 32'h7777_0000, 1);
    cycle(1, 1, 32'h0, 32'h0, 1);
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1, 32'h0000_5000 + 32'(4*k), 32'h5, 0);
      if (k < 15) check("rst_no_stale_val", ostream_val, 1'b0);
    end
    for (int k = 0; k < 16; k++) check("rst_slot5", out_data[32*k +: 32], 32'h5);
    idle(1);

    // All beats to slot 3
    for (int k = 0; k < 16; k++) cycle(0, 1, 32'h0000_600C, 32'(k + 1), 0);
    for (int k = 0; k < 16; k++)
      check("dup_slot", out_data[32*k +: 32], (k == 3) ? 32'd16 : 32'd0);
    idle(1);

    // Random traffic with occasional reset
    for (int c = 0; c < 3000; c++)
      cycle(($urandom % 200) == 0, ($urandom % 4) != 0,
            {($urandom % 4 == 0) ? 26'h3FF_FFFF : 26'($urandom), 6'($urandom)},
            $urandom, ($urandom % 3) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
